seven_seg_scan: RTL
===================

// Module: seven_seg_scan
// PURPOSE
//   Time-multiplexed N-digit seven-segment driver: latches a packed BCD word and per-digit decimal points.
//   Decodes one digit per scan slot and drives shared segment lines plus one-hot digit enables.
//   Sits between the counter/display datapath and the board's common-anode/cathode display pins.
//   Adds registered scan, anti-ghost dead time, leading-zero blanking and defined invalid-code output.
// PARAMETERS
//   DIGITS      4     number of display digits (>=1); digit 0 = least significant, rightmost
//   PRESCALE    1000  CLK cycles per digit slot (>=2)
//   ACTIVE_LOW  0     1 = invert SEG and AN at the outputs (common-anode boards)
// PORTS
//   CLK       in   1          system clock, rising edge
//   RST       in   1          asynchronous reset, active-high
//   BCD       in   4*DIGITS   packed digit codes, digit i = BCD[4*i+3:4*i]
//   DP        in   DIGITS     decimal point per digit, 1 = lit
//   LOAD      in   1          1 = capture BCD/DP into shadow register on this edge
//   BLANK_LZ  in   1          1 = suppress leading zeros (level, sampled every cycle)
//   SEG       out  8          segments {a,b,c,d,e,f,g,dp}, a = bit 7, 1 = lit before polarity
//   AN        out  DIGITS     one-hot digit enable, bit i = digit i, 1 = on before polarity
//   FRAME     out  1          one-cycle pulse when scan wraps from digit DIGITS-1 to 0
// BEHAVIOUR
//   Reset (async, immediate): cnt=0, idx=0, shadow=0, SEG=all off, AN=all off, FRAME=0.
//   "Off" means 0 when ACTIVE_LOW=0 and 1 when ACTIVE_LOW=1.
//   Shadow: on LOAD=1, shadow <= {BCD,DP} at that edge. A held LOAD re-captures every cycle.
//   Prescaler cnt counts 0..PRESCALE-1 and wraps to 0.
//   Digit index idx advances on the cnt wrap edge: DIGITS-1 -> 0.
//   FRAME is registered: high for exactly the one cycle after the edge where idx goes DIGITS-1 -> 0.
//     DIGITS=1: FRAME pulses once per slot.
//   SEG/AN are registered from the current cnt/idx/shadow/BLANK_LZ: one cycle of latency.
//     LOAD to visible change is therefore 2 edges, provided that digit is in its slot.
//   Dead time: the output cycle derived from cnt==0 drives AN all off; SEG still shows the new glyph.
//     The remaining PRESCALE-1 cycles drive AN one-hot at idx.
//   Decode of codes 0-9 (a..g, dp=0):
//     0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011,
//     5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
//   Codes 10-15 decode per CONFIGURATION; never X.
//   SEG[0] = shadow DP[idx], independent of blanking.
//   Leading-zero blank: digit i>0 shows a..g off when BLANK_LZ=1 and codes of digits DIGITS-1..i are all 0.
//     Digit 0 is never suppressed. A nonzero invalid code counts as nonzero.
//   Reset mid-slot: all outputs go off at once; scan restarts at idx 0 with a dead cycle first.
// CONFIGURATION
//   SEVEN_SEG_SCAN_HEX_EN defined: codes 10-15 show hex glyphs (a..g):
//     A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
//   Not defined: codes 10-15 show a..g all off; dp still follows DP.
// TESTING  (DIGITS=4, PRESCALE=4, ACTIVE_LOW=0 unless noted)
//   1 Scan timing: RST released, shadow 0.
//     -> Each 4-cycle slot: AN=0000 for 1 cycle, then 3 cycles of 0001, 0010, 0100, 1000 in turn.
//     -> FRAME=1 for one cycle every 16 cycles; SEG=11111100 throughout.
//   2 LOAD=1 one cycle, BCD=16'h1234, DP=4'b0100.
//     -> While AN=0001, SEG=01100110. While AN=0010, SEG=11110010.
//     -> While AN=0100, SEG=11011011. While AN=1000, SEG=01100000.
//   3 BLANK_LZ=1, BCD=16'h0050 -> digits 3,2 SEG=00000000; digit 1 SEG=10110110; digit 0 SEG=11111100.
//     BCD=16'h0000 -> only digit 0 shows 11111100.
//   4 BCD=16'h00AF, HEX_EN not defined -> digits 1,0 SEG=00000000.
//     HEX_EN defined -> digit 1 = 11101110, digit 0 = 10001110.
//   5 Assert RST while idx=2, cnt=2 -> SEG/AN/FRAME off in the same cycle, before any edge.
//     After release, the first active AN is 0001, preceded by a dead cycle.
//   6 ACTIVE_LOW=1, scenario 2 -> SEG and AN are the bitwise inverse; reset drives SEG=8'hFF, AN=4'hF.

Source files
------------

// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - display-data and scan-output bundle for seven_seg_scan
interface seven_seg_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                blank_lz;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame;

  modport master (output bcd, dp, load, blank_lz, input seg, an, frame);
  modport slave  (input bcd, dp, load, blank_lz, output seg, an, frame);
endinterface

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed N-digit seven-segment scanner
// Define SEVEN_SEG_SCAN_HEX_EN to show hex glyphs for codes 10-15 (blank otherwise).
module seven_seg_scan #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            rst,
  seven_seg_scan_if.slave bus
);
  localparam int   CW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] bcd_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [7:0]          seg_r;
  logic [DIGITS-1:0]   an_r;
  logic                frame_r;

  logic                cnt_wrap;
  logic                idx_last;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                nonzero_above;
  logic                blank;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0: g = 7'b1111110;
      4'd1: g = 7'b0110000;
      4'd2: g = 7'b1101101;
      4'd3: g = 7'b1111001;
      4'd4: g = 7'b0110011;
      4'd5: g = 7'b1011011;
      4'd6: g = 7'b1011111;
      4'd7: g = 7'b1110000;
      4'd8: g = 7'b1111111;
      4'd9: g = 7'b1111011;
`ifdef SEVEN_SEG_SCAN_HEX_EN
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
`endif
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  assign cnt_wrap = (cnt == CW'(PRESCALE - 1));
  assign idx_last = (idx == IW'(DIGITS - 1));

  // Leading zeros: the current digit is blank only if it and every more significant digit is zero.
  always_comb begin
    cur_code      = 4'd0;
    cur_dp        = 1'b0;
    nonzero_above = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_code = bcd_sh[4*i +: 4];
        cur_dp   = dp_sh[i];
      end
      if (IW'(i) >= idx && bcd_sh[4*i +: 4] != 4'd0) begin
        nonzero_above = 1'b1;
      end
    end
    blank    = bus.blank_lz && (idx != '0) && !nonzero_above;
    seg_next = {(blank ? 7'b0000000 : decode(cur_code)), cur_dp};
    an_next  = (cnt == '0) ? '0 : (DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      bcd_sh  <= '0;
      dp_sh   <= '0;
      seg_r   <= '0;
      an_r    <= '0;
      frame_r <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap) begin
        idx <= idx_last ? '0 : idx + IW'(1);
      end
      if (bus.load) begin
        bcd_sh <= bus.bcd;
        dp_sh  <= bus.dp;
      end
      seg_r   <= seg_next;
      an_r    <= an_next;
      frame_r <= cnt_wrap && idx_last;
    end
  end

  // Registers hold positive logic so reset is "off" for either board polarity.
  assign bus.seg   = seg_r ^ {8{POL}};
  assign bus.an    = an_r ^ {DIGITS{POL}};
  assign bus.frame = frame_r;
endmodule
